// File: rtl/rr_stream_mux_if.sv
// Handshake bundle for rr_stream_mux: N producer channels in, one registered
// output stream out, plus the arbitration mode select.
interface rr_stream_mux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic            mode;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [IDXW-1:0] out_ch;
  logic            out_ready;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_stream_mux.sv
// Registered N:1 stream mux with fixed-priority or round-robin arbitration.
// One word per cycle moves from the winning producer into the output register.
module rr_stream_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  rr_stream_mux_if.slave bus
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic [IDXW-1:0] out_ch_q;
  logic [IDXW-1:0] ptr;

  logic            ld;
  logic            any_v;
  logic            found;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] idx;
  logic [IDXW:0]   sum;
  logic [N-1:0]    rdy;
  logic [W-1:0]    chan [N];

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan[i] = bus.in_data[i*W +: W];
  end

  assign ld    = !out_valid_q || bus.out_ready;
  assign any_v = |bus.in_valid;

  // Search order starts at ptr in round-robin, at 0 in fixed priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = (IDXW+1)'(k);
      if (bus.mode)
        sum = {1'b0, ptr} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(N))
        sum = sum - (IDXW+1)'(N);
      idx = sum[IDXW-1:0];
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (reset_n && ld && any_v)
      rdy[win] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr         <= '0;
    end else if (ld) begin
      if (any_v) begin
        out_valid_q <= 1'b1;
        out_data_q  <= chan[win];
        out_ch_q    <= win;
        if (bus.mode)
          ptr <= (win == IDXW'(N-1)) ? '0 : win + 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_rr_stream_mux;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int IDXW = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  rr_stream_mux_if #(.N(N), .W(W)) bus ();

  rr_stream_mux #(.N(N), .W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] src_data [N];
  logic [N-1:0] src_valid;

  logic            m_ov;
  logic [W-1:0]    m_od;
  logic [IDXW-1:0] m_ch;
  int              m_ptr;
  logic [N-1:0]    m_grant;

  always_comb begin
    bus.in_data  = '0;
    bus.in_valid = src_valid;
    for (int i = 0; i < N; i++)
      bus.in_data[i*W +: W] = src_data[i];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration by the plain rule: scan from start, first valid wins.
  function automatic int winner(logic m, logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = m ? (p + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Called just after a falling edge with inputs already set.
  task automatic tick();
    int w;
    logic ld;
    logic [N-1:0] er;
    #1;
    ld = !m_ov || bus.out_ready;
    w  = winner(bus.mode, src_valid, m_ptr);
    er = '0;
    if (reset_n && ld && w >= 0) er[w] = 1'b1;
    check("in_ready", bus.in_ready, er);
    m_grant = er;
    if (!reset_n) begin
      m_ov = 0; m_od = '0; m_ch = '0; m_ptr = 0;
    end else if (ld) begin
      if (w >= 0) begin
        m_ov = 1'b1;
        m_od = src_data[w];
        m_ch = w[IDXW-1:0];
        if (bus.mode) m_ptr = (w + 1) % N;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    check("out_valid", bus.out_valid, m_ov);
    check("out_data", bus.out_data, m_od);
    check("out_ch", bus.out_ch, m_ch);
    @(negedge clock);
  endtask

  initial begin
    logic [IDXW-1:0] exp_seq [6];
    logic [IDXW-1:0] ch_hold;
    logic [W-1:0]    d_hold;

    m_ov = 0; m_od = '0; m_ch = '0; m_ptr = 0; m_grant = '0;
    bus.mode = 1'b1;
    bus.out_ready = 1'b1;
    src_valid = '1;
    for (int i = 0; i < N; i++) src_data[i] = W'(8'hA0 + i);

    // Reset with all channels valid
    reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_ch", bus.out_ch, 0);
    end

    // Round-robin rotation from ptr = 0
    reset_n = 1'b1;
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int c = 0; c < 6; c++) begin
      tick();
      check("rr_seq_ch", bus.out_ch, exp_seq[c]);
      check("rr_seq_data", bus.out_data, 32'hA0 + exp_seq[c]);
    end

    // Fixed priority: ch0 keeps winning
    bus.mode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fp_ch0", bus.out_ch, 0);
    end
    src_valid[0] = 1'b0;
    tick();
    check("fp_ch1", bus.out_ch, 1);

    // Back to round-robin; ptr held at 2 through fixed priority
    bus.mode = 1'b1;
    exp_seq = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rr_resume_ch", bus.out_ch, exp_seq[c]);
    end

    // Backpressure for 3 cycles, then reload with no bubble
    bus.out_ready = 1'b0;
    ch_hold = bus.out_ch;
    d_hold  = bus.out_data;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_ch", bus.out_ch, ch_hold);
      check("bp_data", bus.out_data, d_hold);
      check("bp_in_ready", m_grant, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", bus.out_valid, 1);
    check("bp_release_ch", bus.out_ch, 2);

    // Single channel back-to-back
    src_valid = 4'b0100;
    src_data[2] = 8'h11;
    tick();
    check("single_d0", bus.out_data, 8'h11);
    check("single_ch", bus.out_ch, 2);
    src_data[2] = 8'h22;
    tick();
    check("single_d1", bus.out_data, 8'h22);
    src_data[2] = 8'h33;
    tick();
    check("single_d2", bus.out_data, 8'h33);
    src_valid = '0;
    tick();
    check("single_idle", bus.out_valid, 0);

    // Reset while output holds a word and ch1 is pending
    src_valid = 4'b0001;
    src_data[0] = 8'h77;
    tick();
    check("mid_load", bus.out_valid, 1);
    src_valid = 4'b0010;
    src_data[1] = 8'h5C;
    bus.out_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ptr_model", m_ptr, 0);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("mid_after_ch", bus.out_ch, 1);
    check("mid_after_data", bus.out_data, 8'h5C);
    src_valid = '0;
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_grant[i]) src_valid[i] = 1'b0;
        if (!src_valid[i] && $urandom_range(0, 1) == 1) begin
          src_valid[i] = 1'b1;
          src_data[i]  = W'($urandom);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
      reset_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
